pmci_vdm_tx_sched: RTL and testbench

- Arbitrates between NUM_REQ MCTP/VDM packet sources for the single PMCI VDM transmit path.
- Drives that path through an AVMM master:
  - polls the VDM flow-control register (FCR) until the transmitter is idle;
  - writes each packet DWORD to the packet data register (PDR);
  - commits the packet with one FCR write.
- Sits between the PMCI firmware/BMC message sources and the PMCI CSR fabric.

---
 rtl/pmci_vdm_tx_pkg.sv | 36 +++
 rtl/pmci_vdm_rr_arb.sv | 29 ++
 rtl/pmci_vdm_tx_sched.sv | 193 +++++++++++++++++++
 tb/tb_pmci_vdm_tx_sched.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmci_vdm_tx_pkg.sv
// Shared constants and state encoding for the PMCI VDM transmit scheduler.
package pmci_vdm_tx_pkg;

  localparam int unsigned FCR_TX_BUSY   = 0;
  localparam int unsigned FCR_TX_FLUSH  = 30;
  localparam int unsigned FCR_TX_COMMIT = 31;

  localparam logic [20:0] DEF_FCR_ADDR = 21'h082000;
  localparam logic [20:0] DEF_PDR_ADDR = 21'h082008;

  typedef enum logic [2:0] {
    IDLE,
    POLL_RD,
    POLL_WAIT,
    DATA,
    DRAIN,
    COMMIT,
    FLUSH
  } state_t;

  function automatic logic [31:0] fcr_commit_word(input logic [15:0] cnt);
    logic [31:0] w;
    w = '0;
    w[FCR_TX_COMMIT] = 1'b1;
    w[15:0] = cnt;
    return w;
  endfunction

  function automatic logic [31:0] fcr_flush_word();
    logic [31:0] w;
    w = '0;
    w[FCR_TX_FLUSH] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/pmci_vdm_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module pmci_vdm_rr_arb #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx
);

  always_comb begin
    int unsigned k;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = (32'(ptr) + i) % NUM_REQ;
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = IW'(k);
      end
    end
  end

endmodule

// File: rtl/pmci_vdm_tx_sched.sv
// Arbitrates VDM packet sources and pushes each packet through the PMCI
// FCR/PDR register pair over an AVMM master (poll idle, write DWORDs, commit).
module pmci_vdm_tx_sched
  import pmci_vdm_tx_pkg::*;
#(
  parameter int unsigned       NUM_REQ  = 2,
  parameter int unsigned       ADDR_W   = 21,
  parameter logic [ADDR_W-1:0] FCR_ADDR = ADDR_W'(DEF_FCR_ADDR),
  parameter logic [ADDR_W-1:0] PDR_ADDR = ADDR_W'(DEF_PDR_ADDR),
  parameter int unsigned       MAX_DW   = 16,
  parameter int unsigned       POLL_MAX = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_sop,
  input  logic [NUM_REQ-1:0]         req_eop,
  input  logic [NUM_REQ*32-1:0]      req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [ADDR_W-1:0]          avmm_address,
  output logic                       avmm_write,
  output logic [31:0]                avmm_writedata,
  output logic                       avmm_read,
  input  logic                       avmm_waitrequest,
  input  logic [31:0]                avmm_readdata,
  input  logic                       avmm_readdatavalid,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       pkt_done,
  output logic                       err_timeout,
  output logic                       err_oversize,
  output logic                       err_proto
);

  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam int unsigned PW = $clog2(POLL_MAX + 1);

  state_t               state, state_nx;
  logic [GW-1:0]        rr_ptr, rr_next, arb_idx;
  logic [NUM_REQ-1:0]   arb_req, arb_grant;
  logic [PW-1:0]        poll_cnt;
  logic [15:0]          dw_cnt;
  logic                 wr_pending, wr_last;
  logic [31:0]          wr_data, g_data;
  logic                 g_valid, g_eop, grant_now, data_acc, over, poll_last;
  logic                 rd_busy, wr_done, rd_unused;

  pmci_vdm_rr_arb #(.NUM_REQ(NUM_REQ), .IW(GW)) u_arb (
    .req   (arb_req),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign arb_req   = req_valid & req_sop;
  assign grant_now = (state == IDLE) && enable && (|arb_grant);
  assign g_valid   = req_valid[grant_id];
  assign g_eop     = req_eop[grant_id];
  assign g_data    = req_data[32*grant_id +: 32];
  assign data_acc  = (state == DATA) && g_valid && !wr_pending;
  assign over      = dw_cnt >= 16'(MAX_DW);
  assign poll_last = poll_cnt == PW'(POLL_MAX - 1);
  assign rd_busy   = avmm_readdata[FCR_TX_BUSY];
  assign rd_unused = ^avmm_readdata;
  assign wr_done   = wr_pending && !avmm_waitrequest;
  assign rr_next   = (32'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
  assign busy      = state != IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    req_ready      = '0;
    avmm_address   = '0;
    avmm_write     = 1'b0;
    avmm_writedata = '0;
    avmm_read      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = req_valid & ~req_sop;
        if (grant_now) state_nx = POLL_RD;
      end
      POLL_RD: begin
        avmm_read    = 1'b1;
        avmm_address = FCR_ADDR;
        if (!avmm_waitrequest) state_nx = POLL_WAIT;
      end
      POLL_WAIT: begin
        if (avmm_readdatavalid) begin
          if (!rd_busy)       state_nx = DATA;
          else if (poll_last) state_nx = DRAIN;
          else                state_nx = POLL_RD;
        end
      end
      DATA: begin
        req_ready[grant_id] = !wr_pending;
        avmm_write          = wr_pending;
        avmm_address        = PDR_ADDR;
        avmm_writedata      = wr_data;
        if (wr_done && wr_last) state_nx = COMMIT;
        // An overflowing beat is never written, so it can share this cycle only with an idle write path.
        if (data_acc && over) state_nx = g_eop ? FLUSH : DRAIN;
      end
      DRAIN: begin
        req_ready[grant_id] = 1'b1;
        if (g_valid && g_eop) state_nx = FLUSH;
      end
      COMMIT: begin
        avmm_write     = 1'b1;
        avmm_address   = FCR_ADDR;
        avmm_writedata = fcr_commit_word(dw_cnt);
        if (!avmm_waitrequest) state_nx = IDLE;
      end
      FLUSH: begin
        avmm_write     = 1'b1;
        avmm_address   = FCR_ADDR;
        avmm_writedata = fcr_flush_word();
        if (!avmm_waitrequest) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      grant_id     <= '0;
      poll_cnt     <= '0;
      dw_cnt       <= '0;
      wr_pending   <= 1'b0;
      wr_last      <= 1'b0;
      wr_data      <= '0;
      pkt_done     <= 1'b0;
      err_timeout  <= 1'b0;
      err_oversize <= 1'b0;
      err_proto    <= 1'b0;
    end else begin
      pkt_done     <= 1'b0;
      err_timeout  <= 1'b0;
      err_oversize <= 1'b0;
      err_proto    <= (state == IDLE) && (|(req_valid & ~req_sop));
      case (state)
        IDLE: if (grant_now) grant_id <= arb_idx;
        POLL_WAIT: begin
          if (avmm_readdatavalid) begin
            if (!rd_busy) begin
              poll_cnt <= '0;
            end else if (poll_last) begin
              poll_cnt    <= '0;
              err_timeout <= 1'b1;
            end else begin
              poll_cnt <= poll_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (wr_done) wr_pending <= 1'b0;
          if (data_acc) begin
            if (over) begin
              err_oversize <= 1'b1;
            end else begin
              dw_cnt     <= dw_cnt + 16'd1;
              wr_data    <= g_data;
              wr_pending <= 1'b1;
              wr_last    <= g_eop;
            end
          end
        end
        COMMIT: begin
          if (!avmm_waitrequest) begin
            pkt_done <= 1'b1;
            rr_ptr   <= rr_next;
            dw_cnt   <= '0;
            wr_last  <= 1'b0;
          end
        end
        FLUSH: begin
          if (!avmm_waitrequest) begin
            rr_ptr  <= rr_next;
            dw_cnt  <= '0;
            wr_last <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pmci_vdm_tx_sched.sv
// Scoreboard bench for pmci_vdm_tx_sched: directed packets, AVMM slave model,
// expected bus transactions queued by the stimulus and checked by a monitor.
module tb_pmci_vdm_tx_sched;

  localparam logic [20:0] FCR = 21'h082000;
  localparam logic [20:0] PDR = 21'h082008;

  typedef struct {
    logic        rd;
    logic [20:0] addr;
    logic [31:0] data;
    logic        gid;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  req_valid = '0, req_sop = '0, req_eop = '0;
  logic [63:0] req_data = '0;
  logic [1:0]  req_ready;
  logic [20:0] avmm_address;
  logic        avmm_write, avmm_read;
  logic [31:0] avmm_writedata;
  logic        avmm_waitrequest = 1'b0;
  logic [31:0] avmm_readdata = '0;
  logic        avmm_readdatavalid = 1'b0;
  logic        busy, pkt_done, err_timeout, err_oversize, err_proto;
  logic [0:0]  grant_id;

  int checks = 0;
  int errors = 0;
  txn_t        sb[$];
  logic [33:0] bq0[$];
  logic [33:0] bq1[$];
  logic [31:0] rd_q[$];
  int unsigned ws = 0;
  int cnt_done = 0, cnt_to = 0, cnt_ovs = 0, cnt_proto = 0;
  int b_done, b_to, b_ovs, b_proto;

  pmci_vdm_tx_sched #(
    .NUM_REQ (2),
    .ADDR_W  (21),
    .FCR_ADDR(21'h082000),
    .PDR_ADDR(21'h082008),
    .MAX_DW  (16),
    .POLL_MAX(4)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .enable            (enable),
    .req_valid         (req_valid),
    .req_sop           (req_sop),
    .req_eop           (req_eop),
    .req_data          (req_data),
    .req_ready         (req_ready),
    .avmm_address      (avmm_address),
    .avmm_write        (avmm_write),
    .avmm_writedata    (avmm_writedata),
    .avmm_read         (avmm_read),
    .avmm_waitrequest  (avmm_waitrequest),
    .avmm_readdata     (avmm_readdata),
    .avmm_readdatavalid(avmm_readdatavalid),
    .busy              (busy),
    .grant_id          (grant_id),
    .pkt_done          (pkt_done),
    .err_timeout       (err_timeout),
    .err_oversize      (err_oversize),
    .err_proto         (err_proto)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic exp_rd(input logic g);
    sb.push_back('{1'b1, FCR, 32'h0, g});
  endtask

  task automatic exp_wr(input logic [20:0] a, input logic [31:0] d, input logic g);
    sb.push_back('{1'b0, a, d, g});
  endtask

  task automatic beat(input int r, input logic s, input logic e, input logic [31:0] d);
    if (r == 0) bq0.push_back({s, e, d});
    else        bq1.push_back({s, e, d});
  endtask

  // n-beat packet with data base, base+1, ...
  task automatic send(input int r, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) beat(r, i == 0, i == n - 1, base + 32'(i));
  endtask

  task automatic snap();
    b_done = cnt_done; b_to = cnt_to; b_ovs = cnt_ovs; b_proto = cnt_proto;
  endtask

  task automatic chk_pulses(input string name, input int d, input int t, input int o, input int p);
    chk({name, "_pkt_done"}, 32'(cnt_done - b_done), 32'(d));
    chk({name, "_err_timeout"}, 32'(cnt_to - b_to), 32'(t));
    chk({name, "_err_oversize"}, 32'(cnt_ovs - b_ovs), 32'(o));
    chk({name, "_err_proto"}, 32'(cnt_proto - b_proto), 32'(p));
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk); #2;
      n++;
    end while (n < 2000 && !(sb.size() == 0 && bq0.size() == 0 && bq1.size() == 0 && !busy));
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL %s_complete: timed out, sb=%0d bq0=%0d bq1=%0d busy=%0d, required all empty and idle",
               name, sb.size(), bq0.size(), bq1.size(), busy);
    end
    repeat (3) @(negedge clk);
    #2;
  endtask

  // Requester driver: presents queue heads, pops what the DUT accepted.
  initial begin : driver
    logic [1:0]  acc;
    logic [33:0] t;
    acc = '0;
    forever begin
      @(negedge clk);
      if (acc[0] && bq0.size() > 0) t = bq0.pop_front();
      if (acc[1] && bq1.size() > 0) t = bq1.pop_front();
      t = (bq0.size() > 0) ? bq0[0] : 34'h0;
      req_valid[0] = (bq0.size() > 0);
      {req_sop[0], req_eop[0], req_data[31:0]} = t;
      t = (bq1.size() > 0) ? bq1[0] : 34'h0;
      req_valid[1] = (bq1.size() > 0);
      {req_sop[1], req_eop[1], req_data[63:32]} = t;
      #1;
      acc = req_valid & req_ready;
    end
  end

  // AVMM slave model and monitor.
  initial begin : monitor
    int unsigned held;
    logic [20:0] h_addr;
    logic [31:0] h_data;
    logic        h_rd, stab_bad, rdv_pend;
    logic [31:0] rdv_val;
    txn_t        e;
    held = 0; stab_bad = 0; rdv_pend = 0; rdv_val = '0;
    h_addr = '0; h_data = '0; h_rd = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        avmm_waitrequest = 0; avmm_readdatavalid = 0; held = 0; rdv_pend = 0; stab_bad = 0;
      end else begin
        avmm_readdatavalid = rdv_pend;
        avmm_readdata      = rdv_pend ? rdv_val : 32'h0;
        rdv_pend           = 0;
        if (avmm_read || avmm_write) begin
          if (held == 0) begin
            h_addr = avmm_address; h_data = avmm_writedata; h_rd = avmm_read;
          end else if (avmm_address !== h_addr || avmm_read !== h_rd ||
                       (avmm_write && avmm_writedata !== h_data)) begin
            stab_bad = 1;
          end
          if (held < ws) begin
            avmm_waitrequest = 1;
            held++;
          end else begin
            avmm_waitrequest = 0;
            if (ws > 0) chk("hold_stable", {31'h0, stab_bad}, 32'h0);
            stab_bad = 0;
            held = 0;
            checks++;
            if (sb.size() == 0) begin
              errors++;
              $display("FAIL avmm_unexpected: got rd=%0d addr=%h data=%h, required no transaction",
                       avmm_read, avmm_address, avmm_writedata);
            end else begin
              e = sb.pop_front();
              if (e.rd !== avmm_read || e.addr !== avmm_address || e.gid !== grant_id[0] ||
                  (!e.rd && e.data !== avmm_writedata)) begin
                errors++;
                $display("FAIL avmm_txn: got rd=%0d addr=%h data=%h gid=%0d, required rd=%0d addr=%h data=%h gid=%0d",
                         avmm_read, avmm_address, avmm_writedata, grant_id, e.rd, e.addr, e.data, e.gid);
              end
            end
            if (avmm_read) begin
              rdv_pend = 1;
              rdv_val  = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
            end
          end
        end else begin
          avmm_waitrequest = 0;
          held = 0;
        end
        cnt_done  += int'(pkt_done);
        cnt_to    += int'(err_timeout);
        cnt_ovs   += int'(err_oversize);
        cnt_proto += int'(err_proto);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin : main
    int n;
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_read", {31'h0, avmm_read}, 32'h0);
    chk("rst_write", {31'h0, avmm_write}, 32'h0);
    chk("rst_addr", {11'h0, avmm_address}, 32'h0);
    chk("rst_grant", {31'h0, grant_id}, 32'h0);
    chk("rst_ready", {30'h0, req_ready}, 32'h0);
    chk("rst_pulses", {28'h0, pkt_done, err_timeout, err_oversize, err_proto}, 32'h0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1; enable = 1;

    // Fairness: both requesters stream single-beat packets; rr pointer starts at 0.
    snap();
    exp_rd(0); exp_wr(PDR, 32'hA0, 0); exp_wr(FCR, 32'h8000_0001, 0);
    exp_rd(1); exp_wr(PDR, 32'hB0, 1); exp_wr(FCR, 32'h8000_0001, 1);
    exp_rd(0); exp_wr(PDR, 32'hA1, 0); exp_wr(FCR, 32'h8000_0001, 0);
    exp_rd(1); exp_wr(PDR, 32'hB1, 1); exp_wr(FCR, 32'h8000_0001, 1);
    beat(0, 1, 1, 32'hA0); beat(0, 1, 1, 32'hA1);
    beat(1, 1, 1, 32'hB0); beat(1, 1, 1, 32'hB1);
    wait_done("fair");
    chk_pulses("fair", 4, 0, 0, 0);

    // Single 3-beat packet from requester 0.
    snap();
    exp_rd(0); exp_wr(PDR, 32'h11, 0); exp_wr(PDR, 32'h22, 0); exp_wr(PDR, 32'h33, 0);
    exp_wr(FCR, 32'h8000_0003, 0);
    beat(0, 1, 0, 32'h11); beat(0, 0, 0, 32'h22); beat(0, 0, 1, 32'h33);
    wait_done("single");
    chk_pulses("single", 1, 0, 0, 0);
    chk("single_grant", {31'h0, grant_id}, 32'h0);

    // Transmitter busy for two polls, then idle.
    snap();
    rd_q.push_back(1); rd_q.push_back(1); rd_q.push_back(0);
    exp_rd(1); exp_rd(1); exp_rd(1);
    exp_wr(PDR, 32'h500, 1); exp_wr(PDR, 32'h501, 1); exp_wr(FCR, 32'h8000_0002, 1);
    send(1, 2, 32'h500);
    wait_done("busy");
    chk_pulses("busy", 1, 0, 0, 0);

    // Busy for POLL_MAX polls: timeout, drain, flush.
    snap();
    for (int i = 0; i < 4; i++) begin rd_q.push_back(1); exp_rd(0); end
    exp_wr(FCR, 32'h4000_0000, 0);
    send(0, 3, 32'h600);
    wait_done("timeout");
    chk_pulses("timeout", 0, 1, 0, 0);

    // 18-beat packet: 16 written, beat 17 flags oversize, beat 18 drained, flush.
    snap();
    exp_rd(1);
    for (int i = 0; i < 16; i++) exp_wr(PDR, 32'h700 + 32'(i), 1);
    exp_wr(FCR, 32'h4000_0000, 1);
    send(1, 18, 32'h700);
    wait_done("oversize");
    chk_pulses("oversize", 0, 0, 1, 0);

    // Exactly MAX_DW beats is a legal packet.
    snap();
    exp_rd(0);
    for (int i = 0; i < 16; i++) exp_wr(PDR, 32'h800 + 32'(i), 0);
    exp_wr(FCR, 32'h8000_0010, 0);
    send(0, 16, 32'h800);
    wait_done("maxdw");
    chk_pulses("maxdw", 1, 0, 0, 0);

    // Waitrequest held 5 cycles on every strobe.
    snap();
    ws = 5;
    exp_rd(1); exp_wr(PDR, 32'hCAFE_0001, 1); exp_wr(PDR, 32'hCAFE_0002, 1);
    exp_wr(FCR, 32'h8000_0002, 1);
    send(1, 2, 32'hCAFE_0001);
    wait_done("waitreq");
    chk_pulses("waitreq", 1, 0, 0, 0);
    ws = 0;

    // Non-sop beat while idle is dropped with err_proto.
    snap();
    beat(1, 0, 1, 32'h77);
    wait_done("proto");
    chk_pulses("proto", 0, 0, 0, 1);

    // enable=0 blocks the grant; the sop beat waits.
    snap();
    enable = 0;
    beat(0, 1, 1, 32'h55);
    repeat (20) @(negedge clk);
    #2;
    chk("disabled_busy", {31'h0, busy}, 32'h0);
    chk("disabled_queued", 32'(bq0.size()), 32'h1);
    exp_rd(0); exp_wr(PDR, 32'h55, 0); exp_wr(FCR, 32'h8000_0001, 0);
    enable = 1;
    wait_done("enable");
    chk_pulses("enable", 1, 0, 0, 0);

    // Reset during DATA after two beats written.
    snap();
    exp_rd(0); exp_wr(PDR, 32'hC0, 0); exp_wr(PDR, 32'hC1, 0);
    send(0, 4, 32'hC0);
    n = 0;
    do begin @(negedge clk); #2; n++; end while (n < 500 && sb.size() != 0);
    chk("midrst_reached", {31'h0, n >= 500}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    chk("midrst_write", {31'h0, avmm_write}, 32'h0);
    chk("midrst_read", {31'h0, avmm_read}, 32'h0);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    bq0.delete(); rd_q.delete(); sb.delete();
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1;
    exp_rd(0); exp_wr(PDR, 32'hD0, 0); exp_wr(PDR, 32'hD1, 0); exp_wr(FCR, 32'h8000_0002, 0);
    send(0, 2, 32'hD0);
    wait_done("postrst");
    chk_pulses("postrst", 1, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
